regbank_ctx_sync: RTL
=====================

// Module: regbank_ctx_sync
// PURPOSE
//  Context-sync controller for the main/shadow CPU register bank pair. Main bank is frozen while
//  interrupt is high; shadow takes all CPU writes. Tracks per-register divergence (dirty bitmap).
//  After interrupt exit, copies dirty registers main->shadow, one per free shadow write slot.
//  Owns the shadow write port and one main read port.
// PARAMETERS
//  REG_NUM     32  registers per bank; AW = $clog2(REG_NUM)
//  DATA_WIDTH  64  register width
// PORTS
//  clk              in   1           clock; all state updates on posedge
//  reset            in   1           synchronous, active-high
//  interrupt        in   1           interrupt context active
//  write_en_cpu     in   1           CPU writeback enable
//  write_addr_cpu   in   AW          CPU writeback address
//  data_in_cpu      in   DATA_WIDTH  CPU writeback data
//  main_write_en    out  1           main bank write enable
//  sync_rd_addr     out  AW          main bank sync read address
//  sync_rd_data     in   DATA_WIDTH  main bank read data (combinational)
//  shadow_write_en  out  1           shadow bank write enable
//  shadow_write_addr out AW          shadow bank write address
//  shadow_data_in   out  DATA_WIDTH  shadow bank write data
//  sync_busy        out  1           state==SYNC; interrupt source must hold off new interrupts
//  sync_done        out  1           1-cycle pulse on the last copy (SYNC->IDLE)
//  dirty_count      out  AW+1        number of set dirty bits
//  overrun          out  1           sticky: interrupt rose while in SYNC
// BEHAVIOUR
//  - Reset: state=IDLE, dirty=0, overrun=0, sync_done=0. Reset dominates everything, incl. mid-SYNC.
//  - cpu_wr = write_en_cpu && write_addr_cpu!=0. Address 0 is never dirty or written.
//  - main_write_en = write_en_cpu & ~interrupt (combinational, uses the raw input).
//  - Shadow port mux (combinational): if write_en_cpu, pass CPU addr/data/en (CPU always wins).
//    Else if state==SYNC and dirty!=0: en=1, addr=sync_rd_addr, data=sync_rd_data.
//  - sync_rd_addr = index of lowest set dirty bit (priority encoder); 0 when dirty==0.
//  - Dirty update each posedge:
//    interrupt=1: cpu_wr sets dirty[addr].
//    interrupt=0: cpu_wr clears dirty[addr] (write lands in both banks).
//    SYNC slot granted (no CPU write): clears dirty[sync_rd_addr].
//  - FSM:
//    IDLE: interrupt -> IRQ.
//    IRQ: interrupt falls -> SYNC if dirty!=0 after this cycle's update, else IDLE.
//    SYNC: interrupt=1 -> IRQ and set overrun (dirty bits kept). Otherwise, when the
//      next-state dirty==0 -> IDLE with sync_done=1 registered for exactly 1 cycle.
//  - Latency: first copy in the first SYNC cycle. N dirty registers need N CPU-idle cycles.
//    A CPU write to a dirty register during SYNC clears it without a copy.
//  - dirty_count is combinational popcount of dirty; range 0..REG_NUM-1.
// TESTING
//  1. Reset, irq=1, CPU writes x5=0xAA, x9=0xBB, then irq=0. Expect main_write_en=0 during irq,
//     dirty_count=2, SYNC for 2 cycles copying x5 then x9, sync_done pulse, IDLE.
//  2. In SYNC with x3,x7 dirty, CPU writes x20 on cycle 1. Expect shadow port = CPU x20; copy of
//     x3 deferred to cycle 2, x7 to cycle 3.
//  3. In SYNC with x3,x7 dirty, CPU writes x7. Expect dirty[7] cleared; only x3 is copied.
//  4. In irq, write x0=0xFF. Expect dirty_count=0; irq exit goes IRQ->IDLE with no SYNC and no
//     sync_done.
//  5. In SYNC with 3 dirty, raise irq after the first copy. Expect state IRQ, overrun=1,
//     dirty_count=2. Drop irq: remaining 2 copied.
//  6. Assert reset mid-SYNC. Next cycle: IDLE, dirty_count=0, overrun=0, shadow_write_en=0.

Source files
------------

// File: rtl/regbank_ctx_sync.sv
// regbank_ctx_sync: keeps the shadow register bank consistent with the main bank
// across interrupt context switches. While interrupt is high the main bank is frozen
// and every CPU writeback lands only in the shadow bank, marking that register dirty.
// After the interrupt ends, the dirty registers are copied main->shadow, lowest index
// first, one per cycle in which the CPU is not using the shadow write port.

module regbank_ctx_sync #(
   parameter int  REG_NUM    = 32,
   parameter int  DATA_WIDTH = 64,
   localparam int AW         = $clog2(REG_NUM)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  interrupt,
   input  logic                  write_en_cpu,
   input  logic [AW-1:0]         write_addr_cpu,
   input  logic [DATA_WIDTH-1:0] data_in_cpu,
   output logic                  main_write_en,
   output logic [AW-1:0]         sync_rd_addr,
   input  logic [DATA_WIDTH-1:0] sync_rd_data,
   output logic                  shadow_write_en,
   output logic [AW-1:0]         shadow_write_addr,
   output logic [DATA_WIDTH-1:0] shadow_data_in,
   output logic                  sync_busy,
   output logic                  sync_done,
   output logic [AW:0]           dirty_count,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IRQ  = 2'd1,
      SYNC = 2'd2
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [REG_NUM-1:0] dirty;
   logic [REG_NUM-1:0] dirty_next;
   logic               cpu_wr;
   logic               slot_grant;
   logic               sync_done_next;

   // Register 0 is hardwired, so writes to it never create or clear divergence.
   assign cpu_wr        = write_en_cpu && (write_addr_cpu != '0);
   assign main_write_en = write_en_cpu & ~interrupt;
   assign sync_busy     = (state == SYNC);

   // A copy slot exists only when the CPU leaves the shadow port free. No copy is
   // made in a cycle where interrupt has come back: the dirty bits are handed back
   // to the new interrupt context untouched.
   assign slot_grant = (state == SYNC) && !interrupt && !write_en_cpu && (dirty != '0);

   // Lowest-numbered dirty register is the next one to copy; 0 when nothing is dirty.
   always_comb begin
      sync_rd_addr = '0;
      for (int i = REG_NUM - 1; i >= 1; i--) begin
         if (dirty[i]) sync_rd_addr = AW'(i);
      end
   end

   // Number of registers whose shadow copy differs from main.
   always_comb begin
      dirty_count = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         dirty_count = dirty_count + {{AW{1'b0}}, dirty[i]};
      end
   end

   // Shadow write port: the CPU always wins, otherwise a pending copy uses it.
   always_comb begin
      shadow_write_en   = 1'b0;
      shadow_write_addr = '0;
      shadow_data_in    = '0;
      if (write_en_cpu) begin
         shadow_write_en   = 1'b1;
         shadow_write_addr = write_addr_cpu;
         shadow_data_in    = data_in_cpu;
      end else if (slot_grant) begin
         shadow_write_en   = 1'b1;
         shadow_write_addr = sync_rd_addr;
         shadow_data_in    = sync_rd_data;
      end
   end

   // Divergence tracking: an interrupt-context write diverges a register, a normal
   // write lands in both banks and re-aligns it, and a copy slot re-aligns one.
   always_comb begin
      dirty_next = dirty;
      if (cpu_wr) dirty_next[write_addr_cpu] = interrupt;
      if (slot_grant) dirty_next[sync_rd_addr] = 1'b0;
   end

   // Context FSM: decisions look at the dirty set as it will be after this cycle.
   always_comb begin
      next_state     = state;
      sync_done_next = 1'b0;
      case (state)
         IDLE: begin
            if (interrupt) next_state = IRQ;
         end
         IRQ: begin
            if (!interrupt) next_state = (dirty_next != '0) ? SYNC : IDLE;
         end
         SYNC: begin
            if (interrupt) begin
               next_state = IRQ;
            end else if (dirty_next == '0) begin
               next_state     = IDLE;
               sync_done_next = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, dirty bitmap, completion pulse and sticky overrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dirty     <= '0;
         sync_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= next_state;
         dirty     <= dirty_next;
         sync_done <= sync_done_next;
         if ((state == SYNC) && interrupt) overrun <= 1'b1;
      end
   end

endmodule
